div_issue_ctrl: RTL
===================

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, meaning the number of clk cycles allowed for the combinational 4-bit/2-bit divider array to settle, with legal range 1..15.
REQ-002 The block SHALL have port clk, input, width 1, the single clock, where all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, width 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, width 1, meaning the upstream operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, width 1, meaning the block can accept an operand pair.
REQ-006 The block SHALL have port in_x, input, width 4, the dividend.
REQ-007 The block SHALL have port in_y, input, width 2, the divisor.
REQ-008 The block SHALL have port div_x, output, width 4, the registered dividend driven to the divider array.
REQ-009 The block SHALL have port div_y, output, width 2, the registered divisor driven to the divider array.
REQ-010 The block SHALL have port div_q, input, width 3, the quotient returned from the divider array.
REQ-011 The block SHALL have port div_r, input, width 3, the remainder returned from the divider array.
REQ-012 The block SHALL have port out_valid, output, width 1, meaning the result is valid.
REQ-013 The block SHALL have port out_ready, input, width 1, meaning the downstream stage accepts the result.
REQ-014 The block SHALL have port out_q, output, width 3, the registered quotient.
REQ-015 The block SHALL have port out_r, output, width 3, the registered remainder.
REQ-016 The block SHALL have port out_err, output, width 2, the status code: 00 ok, 01 divide-by-zero, 10 quotient overflow.
REQ-017 The block SHALL have port done_cnt, output, width 8, a wrapping count of completed output handshakes.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, SETTLE and HOLD, where in_ready = (state == IDLE) combinationally.
REQ-019 The block SHALL accept an operand pair on a rising edge E0 where in_valid & in_ready, registering in_x into div_x and in_y into div_y.
REQ-020 div_x and div_y SHALL remain stable until the next accept.
REQ-021 On accept with in_y == 0, the block SHALL bypass SETTLE and go to HOLD at E0, giving out_valid = 1 from E0+1 with out_err = 01, out_q = 0 and out_r = 0.
REQ-022 On accept with in_y == 1 and in_x >= 8 (quotient does not fit in 3 bits), the block SHALL go directly to HOLD with out_err = 10, out_q = 0 and out_r = 0, with the same timing as REQ-021.
REQ-023 On any other accept, the block SHALL enter SETTLE and load a down-counter with SETTLE-1, decrementing it each cycle.
REQ-024 At the edge where the SETTLE counter equals 0, the block SHALL capture div_q into out_q and div_r into out_r, set out_err = 00, and go to HOLD, so that out_valid is 1 from edge E0+SETTLE.
REQ-025 In HOLD, out_valid SHALL be 1 and out_q, out_r and out_err SHALL be held stable.
REQ-026 On an edge where out_valid & out_ready, the block SHALL go to IDLE and increment done_cnt modulo 256, so that in_ready is 1 from the next cycle and no same-cycle turnaround occurs.
REQ-027 out_valid SHALL be 0 in IDLE and in SETTLE.
REQ-028 out_q, out_r and out_err SHALL retain their last values after the handshake until the next capture.
REQ-029 in_valid asserted in SETTLE or HOLD SHALL be ignored, with no change to div_x or div_y.
REQ-030 done_cnt SHALL wrap from 255 to 0 without affecting any other output.
REQ-031 The worst-case issue-to-issue interval SHALL be SETTLE+2 cycles when out_ready is held at 1.

Reset
REQ-032 While rst_n = 0, the block SHALL immediately force state = IDLE and drive div_x = 0, div_y = 0, out_q = 0, out_r = 0, out_err = 00, out_valid = 0, done_cnt = 0 and in_ready = 1.
REQ-033 Any in_valid seen while rst_n = 0 SHALL NOT be accepted.
REQ-034 Reset asserted in SETTLE or HOLD SHALL abort the operation and discard the pending result, without producing a partial out_valid pulse.
REQ-035 Operation SHALL resume on the first rising edge with rst_n = 1.

Verification
REQ-036 The bench SHALL check: with SETTLE = 2, in_x = 13, in_y = 3 accepted at E0 -> out_valid rises at E0+2, out_q = 4, out_r = 1, out_err = 00.
REQ-037 The bench SHALL check: in_x = 7, in_y = 1 -> out_q = 7, out_r = 0, out_err = 00; and in_x = 9, in_y = 1 -> out_valid at E0+1, out_err = 10, out_q = 0, out_r = 0.
REQ-038 The bench SHALL check: in_x = 5, in_y = 0 -> out_valid at E0+1, out_err = 01, with div_y = 0 stable.
REQ-039 The bench SHALL check: out_ready held at 0 for 5 cycles in HOLD while in_valid = 1 with new operands -> outputs stable, in_ready = 0, div_x and div_y unchanged, done_cnt unchanged.
REQ-040 The bench SHALL check: rst_n pulled low one cycle after accept (in SETTLE) -> all outputs at reset values immediately, with no out_valid after release.
REQ-041 The bench SHALL check: 256 back-to-back completed operations -> done_cnt returns to 0, and all 48 (in_x 0..15, in_y 1..3) results match the integer quotient and remainder, or err 10 where applicable.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues one operand pair at a time to an external
// combinational 4-bit/2-bit divider array, waits a fixed number of cycles
// for the array to settle, then holds the registered result until the
// downstream stage takes it. Divide-by-zero and quotient overflow are
// detected up front and skip the settle wait.
module div_issue_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_x,
  input  logic [1:0] in_y,
  output logic [3:0] div_x,
  output logic [1:0] div_y,
  input  logic [2:0] div_q,
  input  logic [2:0] div_r,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_q,
  output logic [2:0] out_r,
  output logic [1:0] out_err,
  output logic [7:0] done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DZ   = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  // Counter load value: the capture edge is the one where the counter reads 0.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] div_x_q, div_x_d;
  logic [1:0] div_y_q, div_y_d;
  logic [2:0] out_q_q, out_q_d;
  logic [2:0] out_r_q, out_r_d;
  logic [1:0] out_err_q, out_err_d;
  logic [7:0] done_cnt_q, done_cnt_d;

  // Next-state and datapath update for the issue/settle/hold sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_x_d    = div_x_q;
    div_y_d    = div_y_q;
    out_q_d    = out_q_q;
    out_r_d    = out_r_q;
    out_err_d  = out_err_q;
    done_cnt_d = done_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          div_x_d = in_x;
          div_y_d = in_y;
          if (in_y == 2'd0) begin
            // No point waiting on the array: the answer is an error code.
            out_q_d   = 3'd0;
            out_r_d   = 3'd0;
            out_err_d = ERR_DZ;
            state_d   = S_HOLD;
          end else if ((in_y == 2'd1) && in_x[3]) begin
            // x/1 with x >= 8 cannot be represented in a 3-bit quotient.
            out_q_d   = 3'd0;
            out_r_d   = 3'd0;
            out_err_d = ERR_OVF;
            state_d   = S_HOLD;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          out_q_d   = div_q;
          out_r_d   = div_r;
          out_err_d = ERR_OK;
          state_d   = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          // Return to IDLE rather than re-accepting on the same edge.
          done_cnt_d = done_cnt_q + 8'd1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      div_x_q    <= 4'd0;
      div_y_q    <= 2'd0;
      out_q_q    <= 3'd0;
      out_r_q    <= 3'd0;
      out_err_q  <= 2'b00;
      done_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_x_q    <= div_x_d;
      div_y_q    <= div_y_d;
      out_q_q    <= out_q_d;
      out_r_q    <= out_r_d;
      out_err_q  <= out_err_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign div_x     = div_x_q;
  assign div_y     = div_y_q;
  assign out_q     = out_q_q;
  assign out_r     = out_r_q;
  assign out_err   = out_err_q;
  assign done_cnt  = done_cnt_q;

endmodule
